// File: rtl/alu_op_issuer.sv
// alu_op_issuer: initiator for the 4-bit ALU operand/control interface.
// Accepts one command at a time, launches registered operands/control into
// the ALU, waits SETTLE_CYC cycles, captures {ResH,ResL} plus flags and
// returns them on a valid/ready response port.
// Optional build macro ALU_OP_ISSUER_STATS_EN adds saturating ov_count and
// zero_count outputs; without it those ports and counters do not exist.
module alu_op_issuer #(
    parameter int SETTLE_CYC = 2,   // launch-to-capture distance, 1..15
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic signed [3:0] cmd_a,
    input  logic signed [3:0] cmd_b,
    output logic              Ctrl1,
    output logic              Ctrl0,
    output logic signed [3:0] A,
    output logic signed [3:0] B,
    input  logic [3:0]        ResH,
    input  logic [3:0]        ResL,
    input  logic              Zero,
    input  logic              Overflow,
    input  logic              Cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_res,
    output logic              rsp_zero,
    output logic              rsp_ov,
    output logic              rsp_cout,
    output logic [1:0]        rsp_op,
    output logic [CNT_W-1:0]  op_count
`ifdef ALU_OP_ISSUER_STATS_EN
    ,
    output logic [7:0]        ov_count,
    output logic [7:0]        zero_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    state_t     state;
    state_t     nxt;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       capture;
    logic       rsp_hs;

    assign accept  = cmd_valid && cmd_ready;
    assign capture = (state == S_WAIT) && (wait_cnt == 4'd1);
    assign rsp_hs  = rsp_valid && rsp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Next-state logic: IDLE -> WAIT on accept, WAIT -> RESP on the capture edge,
    // RESP -> IDLE on the response handshake
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid)       nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd1) nxt = S_RESP;
            S_RESP:  if (rsp_ready)       nxt = S_IDLE;
            default:                      nxt = S_IDLE;
        endcase
    end

    // Handshake outputs; cmd_ready is held low while reset is asserted
    always_comb begin
        cmd_ready = (state == S_IDLE) && rst_n;
        rsp_valid = (state == S_RESP);
    end

    // Operand launch, settle countdown, result capture and completion count.
    // ALU-side outputs keep the last launched values until the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Ctrl1    <= 1'b0;
            Ctrl0    <= 1'b0;
            A        <= '0;
            B        <= '0;
            rsp_op   <= 2'b00;
            wait_cnt <= 4'd0;
            rsp_res  <= 8'h00;
            rsp_zero <= 1'b0;
            rsp_ov   <= 1'b0;
            rsp_cout <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept) begin
                Ctrl1    <= cmd_op[1];
                Ctrl0    <= cmd_op[0];
                A        <= cmd_a;
                B        <= cmd_b;
                rsp_op   <= cmd_op;
                wait_cnt <= SETTLE_LD;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (capture) begin
                rsp_res  <= {ResH, ResL};
                rsp_zero <= Zero;
                rsp_ov   <= Overflow;
                rsp_cout <= Cout;
            end
            if (rsp_hs) op_count <= op_count + CNT_ONE;
        end
    end

`ifdef ALU_OP_ISSUER_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Saturating flag statistics, counted at each response handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov_count   <= 8'h00;
            zero_count <= 8'h00;
        end else if (rsp_hs) begin
            if (rsp_ov)   ov_count   <= sat_inc(ov_count);
            if (rsp_zero) zero_count <= sat_inc(zero_count);
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Testbench for alu_op_issuer: stub ALU, vector table, directed corner
// sequences and randomized ops against a behavioural model.
module tb_alu_op_issuer;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic             Ctrl1, Ctrl0;
    logic [3:0]       A, B;
    logic [3:0]       ResH, ResL;
    logic             Zero, Overflow, Cout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_res;
    logic             rsp_zero, rsp_ov, rsp_cout;
    logic [1:0]       rsp_op;
    logic [CNT_W-1:0] op_count;
`ifdef ALU_OP_ISSUER_STATS_EN
    logic [7:0]       ov_count, zero_count;
`endif

    // stub ALU: either fixed values or a reference function of the launched operands
    logic       stub_auto;
    logic [7:0] stub_res;
    logic       stub_z, stub_ov, stub_c;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    int exp_ovc = 0;
    int exp_zc  = 0;

    always #5 clk = ~clk;

    function automatic logic [10:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa, sb, r;
        logic [7:0] res;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = sa * sb;
            default: r = 32'({a, b});
        endcase
        res = r[7:0];
        return {res, res == 8'h00, (r > 127) || (r < -128), res[4]};
    endfunction

    assign {ResH, ResL, Zero, Overflow, Cout} = stub_auto ? alu_ref({Ctrl1, Ctrl0}, A, B)
                                                          : {stub_res, stub_z, stub_ov, stub_c};

    alu_op_issuer #(.SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .Ctrl1(Ctrl1), .Ctrl0(Ctrl0), .A(A), .B(B),
        .ResH(ResH), .ResL(ResL), .Zero(Zero), .Overflow(Overflow), .Cout(Cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_ov(rsp_ov), .rsp_cout(rsp_cout),
        .rsp_op(rsp_op), .op_count(op_count)
`ifdef ALU_OP_ISSUER_STATS_EN
        , .ov_count(ov_count), .zero_count(zero_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_alu_out", 32'({Ctrl1, Ctrl0, A, B}), 0);
        chk("rst_rsp", 32'({rsp_res, rsp_zero, rsp_ov, rsp_cout, rsp_op}), 0);
        chk("rst_op_count", 32'(op_count), 0);
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_ovc = 0;
        exp_zc  = 0;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("post_rst_op_count", 32'(op_count), 0);
    endtask

    // Present a command and complete the accept edge; returns just after that edge.
    task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int w;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("cmd_ready_before_accept", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_a = 4'($urandom);
        cmd_b = 4'($urandom);
        chk("launch_A", 32'(A), 32'(a));
        chk("launch_B", 32'(B), 32'(b));
        chk("launch_ctrl", 32'({Ctrl1, Ctrl0}), 32'(op));
        chk("launch_cmd_ready", 32'(cmd_ready), 0);
    endtask

    // Wait for the response, check it, stall for 'hold' cycles, then take it.
    task automatic finish(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] er, input logic ez, input logic eo, input logic ec,
                          input int hold);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(SETTLE));
        chk("rsp_res", 32'(rsp_res), 32'(er));
        chk("rsp_flags", 32'({rsp_zero, rsp_ov, rsp_cout}), 32'({ez, eo, ec}));
        chk("rsp_op", 32'(rsp_op), 32'(op));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_rsp", 32'({rsp_res, rsp_zero, rsp_ov, rsp_cout, rsp_op}), 32'({er, ez, eo, ec, op}));
            chk("hold_cmd_ready", 32'(cmd_ready), 0);
            chk("hold_AB", 32'({A, B}), 32'({a, b}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_cnt++;
        if (eo && exp_ovc < 255) exp_ovc++;
        if (ez && exp_zc < 255) exp_zc++;
        chk("op_count", 32'(op_count), 32'(exp_cnt % (1 << CNT_W)));
        chk("rsp_valid_drop", 32'(rsp_valid), 0);
        chk("cmd_ready_after_rsp", 32'(cmd_ready), 1);
`ifdef ALU_OP_ISSUER_STATS_EN
        chk("ov_count", 32'(ov_count), 32'(exp_ovc));
        chk("zero_count", 32'(zero_count), 32'(exp_zc));
`endif
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] a, b;
        logic [7:0] alu_res;
        logic       alu_z, alu_ov, alu_c;
        logic [7:0] exp_res;
        logic       exp_z, exp_ov, exp_c;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  rop;
        logic [3:0]  ra, rb;
        logic [10:0] m;

        vecs[0] = '{2'b00, 4'b1101, 4'b0111, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{2'b01, 4'h3, 4'h3, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 4'hF, 4'hF, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{2'b10, 4'h8, 4'h7, 8'h80, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 4'h7, 4'h8, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{2'b00, 4'h0, 4'h0, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_a = 4'h0;
        cmd_b = 4'h0;
        rsp_ready = 1'b0;
        stub_auto = 1'b0;
        stub_res = 8'h00;
        stub_z = 1'b0;
        stub_ov = 1'b0;
        stub_c = 1'b0;

        do_reset();

        // vector table
        for (int i = 0; i < 6; i++) begin
            stub_res = vecs[i].alu_res;
            stub_z   = vecs[i].alu_z;
            stub_ov  = vecs[i].alu_ov;
            stub_c   = vecs[i].alu_c;
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            finish(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res,
                   vecs[i].exp_z, vecs[i].exp_ov, vecs[i].exp_c, i % 3);
        end

        // settle window: only the value present at the capture edge counts
        stub_res = 8'h00;
        stub_z = 1'b0;
        stub_ov = 1'b0;
        stub_c = 1'b0;
        send(2'b01, 4'h2, 4'h5);
        repeat (SETTLE - 1) begin
            @(posedge clk);
            #1;
        end
        chk("settle_not_early", 32'(rsp_valid), 0);
        stub_res = 8'h3C;
        @(posedge clk);
        #1;
        chk("settle_valid", 32'(rsp_valid), 1);
        stub_res = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("settle_res_stable", 32'(rsp_res), 32'h3C);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_cnt++;
        chk("settle_op_count", 32'(op_count), 32'(exp_cnt % (1 << CNT_W)));

        // backpressure with a competing command held on the input
        do_reset();
        stub_res = 8'h96;
        stub_z = 1'b0;
        stub_ov = 1'b0;
        stub_c = 1'b1;
        send(2'b01, 4'h9, 4'h6);
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_a = 4'h1;
        cmd_b = 4'h2;
        finish(2'b01, 4'h9, 4'h6, 8'h96, 1'b0, 1'b0, 1'b1, 10);
        chk("bp_op_count_one", 32'(op_count), 1);
        chk("bp_AB_held", 32'({A, B}), 32'h96);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("bp_next_A", 32'(A), 32'h1);
        chk("bp_next_B", 32'(B), 32'h2);
        chk("bp_next_ctrl", 32'({Ctrl1, Ctrl0}), 32'b10);
        stub_res = 8'h02;
        finish(2'b10, 4'h1, 4'h2, 8'h02, 1'b0, 1'b0, 1'b1, 0);

        // reset while waiting for the result
        stub_res = 8'h77;
        send(2'b11, 4'hB, 4'hC);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_ovc = 0;
        exp_zc = 0;
        for (int i = 0; i < SETTLE + 4; i++) begin
            chk("rstw_no_rsp", 32'(rsp_valid), 0);
            @(posedge clk);
            #1;
        end
        chk("rstw_op_count", 32'(op_count), 0);
        chk("rstw_AB", 32'({A, B}), 0);
        chk("rstw_cmd_ready", 32'(cmd_ready), 1);
        send(2'b00, 4'h4, 4'h3);
        finish(2'b00, 4'h4, 4'h3, 8'h77, 1'b0, 1'b0, 1'b1, 1);

        // randomized ops against the reference ALU
        stub_auto = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra = 4'($urandom);
            rb = 4'($urandom);
            m = alu_ref(rop, ra, rb);
            send(rop, ra, rb);
            finish(rop, ra, rb, m[10:3], m[2], m[1], m[0], int'($urandom_range(0, 3)));
        end

        // counter wrap and flag statistics
        stub_auto = 1'b0;
        do_reset();
        stub_z = 1'b0;
        stub_ov = 1'b1;
        stub_c = 1'b0;
        for (int i = 0; i < 257; i++) begin
            stub_res = 8'($urandom_range(1, 255));
            rop = 2'($urandom);
            ra = 4'($urandom);
            rb = 4'($urandom);
            send(rop, ra, rb);
            finish(rop, ra, rb, stub_res, 1'b0, 1'b1, 1'b0, 0);
        end
        chk("wrap_op_count", 32'(op_count), 1);
`ifdef ALU_OP_ISSUER_STATS_EN
        chk("wrap_ov_sat", 32'(ov_count), 32'hFF);
        chk("wrap_zero_count", 32'(zero_count), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
